voice_allocator: RTL and testbench

Maps incoming note-on/note-off events onto voice slots of the voice pipeline and issues the per-voice configuration writes (tuning code, note status, velocity, DDS/ADSR strobes) that `voice_controller` consumes on its `i_SPI_*` inputs. It keeps a table of which voice holds which note. It searches that table with a sequential scan FSM and steals the oldest voice when all are busy, if stealing is enabled. It sits between the event decoder upstream and `voice_controller`.

---
 rtl/synth_pkg.sv | 48 ++++
 rtl/voice_allocator_if.sv | 18 +
 rtl/voice_allocator_tuning_rom.sv | 20 ++
 rtl/voice_allocator.sv | 261 ++++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocation path.
// Holds the allocator FSM state enum, the voice-entry struct and the
// equal-tempered tuning function that backs note_tuning_rom.
package synth_pkg;

  localparam int unsigned VOICE_IDX_W = 8;
  localparam int unsigned TUNING_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_WR_DDS  = 2'd2,
    ST_WR_ADSR = 2'd3
  } alloc_state_e;

  // Per-voice occupancy; the age stamp lives alongside because its width is
  // a parameter of the allocator.
  typedef struct packed {
    logic       active;
    logic [6:0] note;
  } voice_entry_t;

  // DDS phase increment for a MIDI note at 48 kHz (A4 = 440 Hz).
  // Top octave (notes 120..131) is tabulated; lower octaves are right shifts.
  function automatic logic [TUNING_W-1:0] tuning_word(input logic [6:0] note);
    logic [6:0]          octave;
    logic [6:0]          semi;
    logic [TUNING_W-1:0] base;
    octave = note / 7'd12;
    semi   = note % 7'd12;
    case (semi)
      7'd0:    base = 32'd749115487;
      7'd1:    base = 32'd793660216;
      7'd2:    base = 32'd840853752;
      7'd3:    base = 32'd890853437;
      7'd4:    base = 32'd943826221;
      7'd5:    base = 32'd999948917;
      7'd6:    base = 32'd1059409159;
      7'd7:    base = 32'd1122404697;
      7'd8:    base = 32'd1189146699;
      7'd9:    base = 32'd1259857069;
      7'd10:   base = 32'd1334772039;
      default: base = 32'd1414142139;
    endcase
    return base >> (7'd10 - octave);
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note event handshake from the event decoder into voice_allocator.
interface voice_allocator_if;
  logic       note_valid;
  logic       note_ready;
  logic       note_on;
  logic [6:0] note_number;
  logic [6:0] velocity;

  modport master (
    output note_valid, note_on, note_number, velocity,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_on, note_number, velocity,
    output note_ready
  );
endinterface

// File: rtl/voice_allocator_tuning_rom.sv
// note_tuning_rom: 128 x 32 registered tuning ROM indexed by note number.
module note_tuning_rom
  import synth_pkg::*;
(
  input  logic                i_clk,
  input  logic [6:0]          i_addr,
  output logic [TUNING_W-1:0] o_data
);

  logic [TUNING_W-1:0] data_d, data_q;

  // Table lookup
  always_comb data_d = tuning_word(i_addr);

  // One-cycle registered read
  always_ff @(posedge i_clk) data_q <= data_d;

  assign o_data = data_q;

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: maps note-on/off events onto voice slots with a sequential
// table scan and issues DDS/ADSR configuration writes to voice_controller.
// Optional feature macro: VOICE_STEAL_EN (steal the oldest voice when full).
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 256,
  parameter int unsigned SEQ_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  voice_allocator_if.slave       note_if,
  output logic [VOICE_IDX_W-1:0] o_SPI_voice_index,
  output logic [TUNING_W-1:0]    o_SPI_tuning_code,
  output logic                   o_SPI_note_status,
  output logic [6:0]             o_SPI_velocity,
  output logic                   o_SPI_flag_dds,
  output logic                   o_SPI_flag_adsr,
  output logic                   o_drop,
  output logic [8:0]             o_active_count
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_e        state_d, state_q;
  logic [IDX_W-1:0]    idx_d, idx_q;
  logic                ev_on_d, ev_on_q;
  logic [6:0]          ev_note_d, ev_note_q;
  logic [6:0]          ev_vel_d, ev_vel_q;
  voice_entry_t        tbl_d [NUM_VOICES];
  voice_entry_t        tbl_q [NUM_VOICES];
  logic [SEQ_W-1:0]    stamp_d [NUM_VOICES];
  logic [SEQ_W-1:0]    stamp_q [NUM_VOICES];
  logic [SEQ_W-1:0]    seq_d, seq_q;
  logic [8:0]          cnt_d, cnt_q;
  logic                match_vld_d, match_vld_q;
  logic [IDX_W-1:0]    match_idx_d, match_idx_q;
  logic                free_vld_d, free_vld_q;
  logic [IDX_W-1:0]    free_idx_d, free_idx_q;
`ifdef VOICE_STEAL_EN
  logic                old_vld_d, old_vld_q;
  logic [IDX_W-1:0]    old_idx_d, old_idx_q;
  logic [SEQ_W-1:0]    old_age_d, old_age_q;
  logic [SEQ_W-1:0]    age;
`endif
  logic [VOICE_IDX_W-1:0] vidx_d, vidx_q;
  logic [TUNING_W-1:0] tune_d, tune_q;
  logic                status_d, status_q;
  logic [6:0]          vel_d, vel_q;
  logic                fdds_d, fdds_q;
  logic                fadsr_d, fadsr_q;
  logic                drop_d, drop_q;
  voice_entry_t        cur;
  logic                hit;
  logic [IDX_W-1:0]    tgt;
  logic [6:0]          rom_addr;
  logic [TUNING_W-1:0] rom_data;

  // ROM address follows the input on acceptance, then holds the latched note
  always_comb begin
    rom_addr = ev_note_q;
    if (state_q == ST_IDLE && note_if.note_valid) rom_addr = note_if.note_number;
  end

  note_tuning_rom u_rom (
    .i_clk  (i_clk),
    .i_addr (rom_addr),
    .o_data (rom_data)
  );

  // FSM, scan candidate tracking, table update and write sequencing
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ev_on_d     = ev_on_q;
    ev_note_d   = ev_note_q;
    ev_vel_d    = ev_vel_q;
    tbl_d       = tbl_q;
    stamp_d     = stamp_q;
    seq_d       = seq_q;
    cnt_d       = cnt_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
`ifdef VOICE_STEAL_EN
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    age         = '0;
`endif
    vidx_d      = vidx_q;
    tune_d      = tune_q;
    status_d    = status_q;
    vel_d       = vel_q;
    fdds_d      = 1'b0;
    fadsr_d     = 1'b0;
    drop_d      = 1'b0;
    cur         = tbl_q[idx_q];
    hit         = 1'b0;
    tgt         = '0;
    case (state_q)
      ST_IDLE: begin
        if (note_if.note_valid) begin
          ev_on_d     = note_if.note_on;
          ev_note_d   = note_if.note_number;
          ev_vel_d    = note_if.velocity;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
`ifdef VOICE_STEAL_EN
          old_vld_d   = 1'b0;
`endif
          idx_d       = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!match_vld_d && cur.active && cur.note == ev_note_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!free_vld_d && !cur.active) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
`ifdef VOICE_STEAL_EN
        age = seq_q - stamp_q[idx_q];
        if (cur.active && (!old_vld_d || age > old_age_d)) begin
          old_vld_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = age;
        end
`endif
        // Resolution uses the candidates including the last entry just scanned
        if (idx_q == LAST_IDX) begin
          if (ev_on_q) begin
            hit = 1'b1;
            if (match_vld_d) begin
              tgt = match_idx_d;
            end else if (free_vld_d) begin
              tgt   = free_idx_d;
              cnt_d = cnt_q + 9'd1;
            end else begin
`ifdef VOICE_STEAL_EN
              tgt = old_idx_d;
`else
              hit = 1'b0;
`endif
            end
            if (hit) begin
              tbl_d[tgt]   = '{active: 1'b1, note: ev_note_q};
              stamp_d[tgt] = seq_q;
              seq_d        = seq_q + SEQ_W'(1);
              vidx_d       = VOICE_IDX_W'(tgt);
              tune_d       = rom_data;
              fdds_d       = 1'b1;
              state_d      = ST_WR_DDS;
            end else begin
              drop_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (match_vld_d) begin
            tbl_d[match_idx_d].active = 1'b0;
            cnt_d    = cnt_q - 9'd1;
            vidx_d   = VOICE_IDX_W'(match_idx_d);
            status_d = 1'b0;
            vel_d    = '0;
            fadsr_d  = 1'b1;
            state_d  = ST_WR_ADSR;
          end else begin
            drop_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_WR_DDS: begin
        status_d = 1'b1;
        vel_d    = ev_vel_q;
        fadsr_d  = 1'b1;
        state_d  = ST_WR_ADSR;
      end
      ST_WR_ADSR: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; table cleared on reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ev_on_q     <= 1'b0;
      ev_note_q   <= '0;
      ev_vel_q    <= '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        tbl_q[i]   <= '0;
        stamp_q[i] <= '0;
      end
      seq_q       <= '0;
      cnt_q       <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
`ifdef VOICE_STEAL_EN
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
`endif
      vidx_q      <= '0;
      tune_q      <= '0;
      status_q    <= 1'b0;
      vel_q       <= '0;
      fdds_q      <= 1'b0;
      fadsr_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ev_on_q     <= ev_on_d;
      ev_note_q   <= ev_note_d;
      ev_vel_q    <= ev_vel_d;
      tbl_q       <= tbl_d;
      stamp_q     <= stamp_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
`ifdef VOICE_STEAL_EN
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
`endif
      vidx_q      <= vidx_d;
      tune_q      <= tune_d;
      status_q    <= status_d;
      vel_q       <= vel_d;
      fdds_q      <= fdds_d;
      fadsr_q     <= fadsr_d;
      drop_q      <= drop_d;
    end
  end

  // Strobes and ready are masked while reset is asserted so nothing leaks
  // out in the reset cycle itself
  assign note_if.note_ready = (state_q == ST_IDLE) && !i_reset;
  assign o_SPI_voice_index  = vidx_q;
  assign o_SPI_tuning_code  = tune_q;
  assign o_SPI_note_status  = status_q;
  assign o_SPI_velocity     = vel_q;
  assign o_SPI_flag_dds     = fdds_q && !i_reset;
  assign o_SPI_flag_adsr    = fadsr_q && !i_reset;
  assign o_drop             = drop_q && !i_reset;
  assign o_active_count     = cnt_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (NUM_VOICES = 4).
// Define VOICE_STEAL_EN for both bench and RTL to exercise voice stealing.
module tb_voice_allocator;

  localparam int unsigned NV  = 4;
  localparam int          LAT = NV + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  o_idx;
  logic [31:0] o_tune;
  logic        o_status;
  logic [6:0]  o_vel;
  logic        o_fdds;
  logic        o_fadsr;
  logic        o_drop;
  logic [8:0]  o_count;

  voice_allocator_if nif ();

  voice_allocator #(.NUM_VOICES(NV), .SEQ_W(16)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .note_if           (nif),
    .o_SPI_voice_index (o_idx),
    .o_SPI_tuning_code (o_tune),
    .o_SPI_note_status (o_status),
    .o_SPI_velocity    (o_vel),
    .o_SPI_flag_dds    (o_fdds),
    .o_SPI_flag_adsr   (o_fadsr),
    .o_drop            (o_drop),
    .o_active_count    (o_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // kind: 0 = DDS write, 1 = ADSR write, 2 = drop
  typedef struct {
    int kind;
    int cyc;
    int idx;
    int note;
    int status;
    int vel;
  } exp_t;
  exp_t exp_q[$];

  // Reference voice table
  bit m_act [NV];
  int m_note [NV];
  int m_stamp [NV];
  int m_seq;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic real ideal_tuning(input int n);
    return 440.0 * $pow(2.0, (n - 69) / 12.0) * 4294967296.0 / 48000.0;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NV; i++) if (m_act[i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 1'b0; m_note[i] = 0; m_stamp[i] = 0;
    end
    m_seq = 0;
  endtask

  // Apply the allocation rules to the reference table and queue the writes
  task automatic model_event(input bit on, input int note, input int vel, input int t);
    int   match = -1;
    int   tgt   = -1;
    int   best_age = -1;
    exp_t e;
    for (int i = NV - 1; i >= 0; i--) if (m_act[i] && m_note[i] == note) match = i;
    if (on) begin
      tgt = match;
      if (tgt < 0) for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) tgt = i;
`ifdef VOICE_STEAL_EN
      if (tgt < 0) begin
        for (int i = 0; i < NV; i++) begin
          int age = (m_seq - m_stamp[i]) & 16'hFFFF;
          if (age > best_age) begin best_age = age; tgt = i; end
        end
      end
`endif
      if (tgt >= 0) begin
        m_act[tgt] = 1'b1; m_note[tgt] = note; m_stamp[tgt] = m_seq;
        m_seq = (m_seq + 1) & 16'hFFFF;
        e = '{kind: 0, cyc: t + LAT, idx: tgt, note: note, status: 1, vel: vel};
        exp_q.push_back(e);
        e = '{kind: 1, cyc: t + LAT + 1, idx: tgt, note: note, status: 1, vel: vel};
        exp_q.push_back(e);
      end else begin
        e = '{kind: 2, cyc: t + LAT, idx: 0, note: note, status: 0, vel: 0};
        exp_q.push_back(e);
      end
    end else if (match >= 0) begin
      m_act[match] = 1'b0;
      e = '{kind: 1, cyc: t + LAT, idx: match, note: note, status: 0, vel: 0};
      exp_q.push_back(e);
    end else begin
      e = '{kind: 2, cyc: t + LAT, idx: 0, note: note, status: 0, vel: 0};
      exp_q.push_back(e);
    end
  endtask

  task automatic mon_check(input int kind);
    exp_t e;
    real  ideal;
    real  diff;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_output: kind %0d seen at cycle %0d, none expected", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("out_kind", kind, e.kind);
    chk("out_cycle", cyc, e.cyc);
    if (kind == 2) return;
    chk("voice_index", o_idx, e.idx);
    if (kind == 0) begin
      ideal = ideal_tuning(e.note);
      diff  = real'(o_tune) - ideal;
      if (diff < 0.0) diff = -diff;
      checks++;
      if (diff > ideal * 1.0e-4 + 2.0) begin
        failures++;
        $display("FAIL tuning_code: got %0d, expected ~%0.1f (note %0d)", o_tune, ideal, e.note);
      end
    end else begin
      chk("note_status", o_status, e.status);
      chk("adsr_velocity", o_vel, e.vel);
    end
  endtask

  // Monitor: every strobe or drop pulse consumes one scoreboard entry
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_fdds)  mon_check(0);
      if (o_fadsr) mon_check(1);
      if (o_drop)  mon_check(2);
    end
  end

  task automatic wait_ready(output bit ok);
    int waited = 0;
    @(negedge clk);
    while (!nif.note_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    ok = nif.note_ready;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL ready_timeout: note_ready still 0 after %0d cycles", waited);
    end
  endtask

  task automatic issue(input bit on, input int note, input int vel);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    nif.note_valid  = 1'b1;
    nif.note_on     = on;
    nif.note_number = 7'(note);
    nif.velocity    = 7'(vel);
    model_event(on, note, vel, cyc);
    @(posedge clk);
    #1;
    nif.note_valid  = 1'b0;
    nif.note_on     = 1'($urandom);
    nif.note_number = 7'($urandom);
    nif.velocity    = 7'($urandom);
    chk("busy_not_ready", nif.note_ready, 0);
    wait_ready(ok);
    if (ok) chk("active_count", o_count, model_count());
  endtask

  // Hold reset for the cycle following the current point (caller is #1 past
  // a posedge), check masking, then release and check the reset state.
  task automatic hold_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", nif.note_ready, 0);
    chk("rst_no_dds", o_fdds, 0);
    chk("rst_no_adsr", o_fadsr, 0);
    chk("rst_no_drop", o_drop, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("post_rst_ready", nif.note_ready, 1);
    chk("post_rst_count", o_count, 0);
    chk("post_rst_index", o_idx, 0);
    chk("post_rst_tuning", o_tune, 0);
    chk("post_rst_status", o_status, 0);
    chk("post_rst_vel", o_vel, 0);
  endtask

  task automatic sync_reset();
    @(posedge clk);
    #1;
    hold_reset();
  endtask

  task automatic start_unchecked(input int note);
    bit ok;
    wait_ready(ok);
    nif.note_valid  = 1'b1;
    nif.note_on     = 1'b1;
    nif.note_number = 7'(note);
    nif.velocity    = 7'd90;
    @(posedge clk);
    #1;
    nif.note_valid  = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    nif.note_valid  = 1'b0;
    nif.note_on     = 1'b0;
    nif.note_number = '0;
    nif.velocity    = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    hold_reset();

    // Single note-on after reset
    issue(1'b1, 69, 100);
    chk("t1_count", o_count, 1);

    // Allocate, release the middle voice, reuse it
    sync_reset();
    issue(1'b1, 60, 80);
    issue(1'b1, 62, 81);
    issue(1'b1, 64, 82);
    issue(1'b0, 62, 99);
    chk("t2_count_after_off", o_count, 2);
    issue(1'b1, 65, 83);
    chk("t2_count_after_reuse", o_count, 3);

    // Retrigger
    sync_reset();
    issue(1'b1, 60, 70);
    issue(1'b1, 60, 71);
    chk("t3_count", o_count, 1);

    // Overflow: steal or drop
    sync_reset();
    for (int n = 60; n <= 64; n++) issue(1'b1, n, 50 + n);
    chk("t4_count", o_count, 4);

    // Note-off of a note never on
    sync_reset();
    issue(1'b0, 50, 10);

    // Reset during SCAN: no strobes, then clean allocation to voice 0
    start_unchecked(72);
    @(posedge clk);
    #1;
    hold_reset();
    issue(1'b1, 61, 40);
    chk("t6_count", o_count, 1);

    // Reset in the cycle the DDS strobe would appear
    start_unchecked(74);
    repeat (NV) @(posedge clk);
    #1;
    hold_reset();

    // Randomized traffic over a note range wider than the voice count
    for (int k = 0; k < 120; k++) begin
      bit on = ($urandom_range(0, 9) < 6);
      int note = on ? int'($urandom_range(60, 67)) : int'($urandom_range(58, 67));
      int vel = int'($urandom_range(1, 127));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(on, note, vel);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
